// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - E/M write-hazard stall, D-stage forward select and MDU busy window
module hazard_scoreboard #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       d_valid,
   input  logic [4:0] d_rs,
   input  logic [4:0] d_rt,
   input  logic [1:0] d_rs_tuse,
   input  logic [1:0] d_rt_tuse,
   input  logic       d_write_enable,
   input  logic [4:0] d_write_number,
   input  logic [1:0] d_tnew,
   input  logic       d_md_start,
   input  logic       d_md_div,
   input  logic       d_md_use,
   output logic       stall,
   output logic [1:0] fwd_rs_sel,
   output logic [1:0] fwd_rt_sel,
   output logic       md_busy
);

   // Counter reload values; the counter is 4 bits, so both must fit in 1..15.
   localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
   localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

   // E entry: pending GPR write of the instruction in E, plus its MDU start flags.
   logic       e_valid;
   logic [4:0] e_number;
   logic [1:0] e_tnew;
   logic       e_md;
   logic       e_div;

   // M entry: pending GPR write of the instruction in M.
   logic       m_valid;
   logic [4:0] m_number;
   logic [1:0] m_tnew;

   logic [3:0] cnt;

   logic       rs_stall;
   logic       rt_stall;
   logic       md_stall;
   logic       d_issue;

   // A source stalls when a producer in E or M will not have its result by the time it is used.
   function automatic logic gpr_stall(
      input logic       valid_d,
      input logic [4:0] src,
      input logic [1:0] tuse,
      input logic       ev,
      input logic [4:0] en,
      input logic [1:0] et,
      input logic       mv,
      input logic [4:0] mn,
      input logic [1:0] mt
   );
      logic hit;
      hit = 1'b0;
      if (valid_d && (src != 5'd0) && (tuse != 2'd3)) begin
         if (ev && (en == src) && (et > tuse)) hit = 1'b1;
         if (mv && (mn == src) && (mt > tuse)) hit = 1'b1;
      end
      return hit;
   endfunction

   // The newest producer whose result already exists supplies the operand; E beats M.
   function automatic logic [1:0] fwd_pick(
      input logic [4:0] src,
      input logic       ev,
      input logic [4:0] en,
      input logic [1:0] et,
      input logic       mv,
      input logic [4:0] mn,
      input logic [1:0] mt
   );
      logic [1:0] sel;
      sel = 2'd0;
      if (ev && (en == src) && (et == 2'd0)) begin
         sel = 2'd1;
      end else if (mv && (mn == src) && (mt == 2'd0)) begin
         sel = 2'd2;
      end
      return sel;
   endfunction

   // Combinational hazard decision from the D inputs and the current E/M/MDU state.
   always_comb begin
      md_busy    = (cnt != 4'd0) | e_md;
      rs_stall   = gpr_stall(d_valid, d_rs, d_rs_tuse, e_valid, e_number, e_tnew,
                             m_valid, m_number, m_tnew);
      rt_stall   = gpr_stall(d_valid, d_rt, d_rt_tuse, e_valid, e_number, e_tnew,
                             m_valid, m_number, m_tnew);
      md_stall   = d_valid & d_md_use & md_busy;
      stall      = rs_stall | rt_stall | md_stall;
      d_issue    = d_valid & ~stall;
      fwd_rs_sel = fwd_pick(d_rs, e_valid, e_number, e_tnew, m_valid, m_number, m_tnew);
      fwd_rt_sel = fwd_pick(d_rt, e_valid, e_number, e_tnew, m_valid, m_number, m_tnew);
   end

   // Advance the pipeline tracker: E moves to M, D (or a bubble) enters E.
   always_ff @(posedge clk) begin
      if (reset) begin
         e_valid  <= 1'b0;
         e_number <= 5'd0;
         e_tnew   <= 2'd0;
         e_md     <= 1'b0;
         e_div    <= 1'b0;
         m_valid  <= 1'b0;
         m_number <= 5'd0;
         m_tnew   <= 2'd0;
      end else begin
         m_valid  <= e_valid;
         m_number <= e_number;
         m_tnew   <= (e_tnew == 2'd0) ? 2'd0 : e_tnew - 2'd1;
         if (d_issue) begin
            // Writes to $0 are discarded by the GRF, so they never create an entry.
            e_valid  <= d_write_enable && (d_write_number != 5'd0);
            e_number <= d_write_number;
            e_tnew   <= d_tnew;
            e_md     <= d_md_start;
            e_div    <= d_md_start & d_md_div;
         end else begin
            e_valid  <= 1'b0;
            e_number <= 5'd0;
            e_tnew   <= 2'd0;
            e_md     <= 1'b0;
            e_div    <= 1'b0;
         end
      end
   end

   // MDU busy counter: loaded as a mult/div leaves E, then counts down to idle.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt <= 4'd0;
      end else if (e_md && e_div) begin
         cnt <= DIV_LOAD;
      end else if (e_md) begin
         cnt <= MULT_LOAD;
      end else if (cnt != 4'd0) begin
         cnt <= cnt - 4'd1;
      end
   end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - scoreboard bench for hazard_scoreboard against an issue-history model
module tb_hazard_scoreboard;

   localparam int MULT_C = 5;
   localparam int DIV_C  = 10;
   localparam int HIST   = 4096;

   logic       clk = 1'b0;
   logic       reset;
   logic       d_valid;
   logic [4:0] d_rs, d_rt;
   logic [1:0] d_rs_tuse, d_rt_tuse;
   logic       d_write_enable;
   logic [4:0] d_write_number;
   logic [1:0] d_tnew;
   logic       d_md_start, d_md_div, d_md_use;
   logic       stall;
   logic [1:0] fwd_rs_sel, fwd_rt_sel;
   logic       md_busy;

   hazard_scoreboard #(.MULT_CYCLES(MULT_C), .DIV_CYCLES(DIV_C)) dut (
      .clk(clk), .reset(reset), .d_valid(d_valid),
      .d_rs(d_rs), .d_rt(d_rt), .d_rs_tuse(d_rs_tuse), .d_rt_tuse(d_rt_tuse),
      .d_write_enable(d_write_enable), .d_write_number(d_write_number), .d_tnew(d_tnew),
      .d_md_start(d_md_start), .d_md_div(d_md_div), .d_md_use(d_md_use),
      .stall(stall), .fwd_rs_sel(fwd_rs_sel), .fwd_rt_sel(fwd_rt_sel), .md_busy(md_busy)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       st;
      logic [1:0] frs;
      logic [1:0] frt;
      logic       busy;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   bit   running = 0;

   // Model: which instruction issued in each cycle, and the last MDU start.
   bit         iss_w[HIST];
   logic [4:0] iss_num[HIST];
   int         iss_tnew[HIST];
   int         cyc = 0;
   int         clear_from = 0;
   int         last_md = -100;
   int         md_len = 0;
   logic       last_st = 0;

   function automatic void chk(input string name, input logic [3:0] act, input logic [3:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, req);
      end
   endfunction

   // A producer issued in cycle i is in E during i+1 and M during i+2; its remaining
   // latency shrinks by one per stage, never below zero.
   function automatic void src_eval(input int t, input logic [4:0] s, input logic [1:0] tuse,
                                    output logic st, output logic [1:0] f);
      int i, rem;
      st = 0;
      f  = 0;
      i  = t - 1;
      if (i > clear_from && iss_w[i] && iss_num[i] == s) begin
         rem = iss_tnew[i];
         if (rem > int'(tuse)) st = 1;
         if (rem == 0) f = 2'd1;
      end
      i = t - 2;
      if (i > clear_from && iss_w[i] && iss_num[i] == s) begin
         rem = (iss_tnew[i] > 0) ? iss_tnew[i] - 1 : 0;
         if (rem > int'(tuse)) st = 1;
         if (rem == 0 && f == 2'd0) f = 2'd2;
      end
      if (!d_valid || s == 5'd0 || tuse == 2'd3) st = 0;
   endfunction

   // Compute expectation for the current cycle, queue it, record the issue, advance a clock.
   task automatic step();
      exp_t e;
      logic s1, s2;
      s1 = 0; s2 = 0;
      src_eval(cyc, d_rs, d_rs_tuse, s1, e.frs);
      src_eval(cyc, d_rt, d_rt_tuse, s2, e.frt);
      e.busy = (last_md > clear_from) && (cyc >= last_md + 1) && (cyc <= last_md + md_len + 1);
      e.st   = s1 | s2 | (d_valid & d_md_use & e.busy);
      exp_q.push_back(e);
      last_st = e.st;
      iss_w[cyc] = 0;
      if (reset) begin
         clear_from = cyc;
      end else if (d_valid && !e.st) begin
         iss_w[cyc]    = d_write_enable && (d_write_number != 5'd0);
         iss_num[cyc]  = d_write_number;
         iss_tnew[cyc] = int'(d_tnew);
         if (d_md_start) begin
            last_md = cyc;
            md_len  = d_md_div ? DIV_C : MULT_C;
         end
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic set_d(input logic v, input logic [4:0] rs, input logic [1:0] rsu,
                        input logic [4:0] rt, input logic [1:0] rtu, input logic we,
                        input logic [4:0] wn, input logic [1:0] tn, input logic ms,
                        input logic md, input logic mu);
      d_valid = v; d_rs = rs; d_rs_tuse = rsu; d_rt = rt; d_rt_tuse = rtu;
      d_write_enable = we; d_write_number = wn; d_tnew = tn;
      d_md_start = ms; d_md_div = md; d_md_use = mu;
   endtask

   task automatic drain(input int k);
      set_d(0, 0, 3, 0, 3, 0, 0, 0, 0, 0, 0);
      for (int j = 0; j < k; j++) step();
   endtask

   // Hold the current D instruction until the DUT stops stalling; report stall cycles and rs select.
   task automatic issue_count(output int n, output logic [1:0] frs);
      n = 0;
      frs = 2'd3;
      for (int k = 0; k < 40; k++) begin
         #1;
         if (!stall) begin
            frs = fwd_rs_sel;
            step();
            return;
         end
         n++;
         step();
      end
      n = -1;
   endtask

   // Monitor: compare each cycle's outputs against the queued expectation.
   always @(negedge clk) begin
      exp_t e;
      if (running) begin
         if (exp_q.size() == 0) begin
            chk("scoreboard_empty", 4'd1, 4'd0);
         end else begin
            e = exp_q.pop_front();
            chk("stall", {3'd0, stall}, {3'd0, e.st});
            chk("fwd_rs_sel", {2'd0, fwd_rs_sel}, {2'd0, e.frs});
            chk("fwd_rt_sel", {2'd0, fwd_rt_sel}, {2'd0, e.frt});
            chk("md_busy", {3'd0, md_busy}, {3'd0, e.busy});
         end
      end
   end

   initial begin
      int n;
      logic [1:0] f;
      reset = 1;
      set_d(0, 0, 3, 0, 3, 0, 0, 0, 0, 0, 0);
      repeat (3) @(posedge clk);
      #1;
      reset = 0;
      cyc = 1;
      running = 1;

      // Empty state right after reset: a reader of $1 neither stalls nor forwards.
      set_d(1, 1, 0, 1, 0, 1, 2, 0, 0, 0, 1);
      #1;
      chk("reset_stall", {3'd0, stall}, 4'd0);
      chk("reset_fwd", {2'd0, fwd_rs_sel}, 4'd0);
      chk("reset_md_busy", {3'd0, md_busy}, 4'd0);
      step();
      drain(4);

      // lw $1 then addu $3,$1,$2
      set_d(1, 0, 3, 0, 3, 1, 1, 2, 0, 0, 0);
      issue_count(n, f);
      set_d(1, 1, 1, 2, 1, 1, 3, 0, 0, 0, 0);
      issue_count(n, f);
      chk("lw_use_stalls", 4'(n), 4'd1);
      chk("lw_use_fwd", {2'd0, f}, 4'd0);
      drain(4);

      // addu $2 then beq $2,$0
      set_d(1, 0, 1, 0, 1, 1, 2, 1, 0, 0, 0);
      issue_count(n, f);
      set_d(1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      issue_count(n, f);
      chk("alu_branch_stalls", 4'(n), 4'd1);
      chk("alu_branch_fwd", {2'd0, f}, 4'd2);
      drain(4);

      // two writers of $4, then a reader: E wins
      set_d(1, 0, 1, 0, 1, 1, 4, 0, 0, 0, 0);
      issue_count(n, f);
      issue_count(n, f);
      set_d(1, 4, 0, 0, 3, 0, 0, 0, 0, 0, 0);
      issue_count(n, f);
      chk("e_priority_stalls", 4'(n), 4'd0);
      chk("e_priority_fwd", {2'd0, f}, 4'd1);
      drain(4);

      // lw $0 then a reader of $0
      set_d(1, 0, 3, 0, 3, 1, 0, 2, 0, 0, 0);
      issue_count(n, f);
      set_d(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      issue_count(n, f);
      chk("zero_reg_stalls", 4'(n), 4'd0);
      chk("zero_reg_fwd", {2'd0, f}, 4'd0);
      drain(4);

      // mult then mflo, div then mflo
      set_d(1, 1, 1, 2, 1, 0, 0, 0, 1, 0, 1);
      issue_count(n, f);
      set_d(1, 0, 3, 0, 3, 1, 5, 0, 0, 0, 1);
      issue_count(n, f);
      chk("mult_mflo_stalls", 4'(n), 4'(MULT_C + 1));
      drain(4);
      set_d(1, 1, 1, 2, 1, 0, 0, 0, 1, 1, 1);
      issue_count(n, f);
      set_d(1, 0, 3, 0, 3, 1, 5, 0, 0, 0, 1);
      issue_count(n, f);
      chk("div_mflo_stalls", 4'(n), 4'(DIV_C + 1));
      drain(4);

      // div, then reset three cycles later
      set_d(1, 1, 1, 2, 1, 0, 0, 0, 1, 1, 1);
      issue_count(n, f);
      drain(2);
      reset = 1;
      step();
      reset = 0;
      set_d(1, 0, 3, 0, 3, 1, 5, 0, 0, 0, 1);
      #1;
      chk("post_reset_md_busy", {3'd0, md_busy}, 4'd0);
      issue_count(n, f);
      chk("post_reset_mflo_stalls", 4'(n), 4'd0);
      drain(4);

      // Randomized traffic; D is held while the model expects a stall.
      for (int k = 0; k < 2000; k++) begin
         int r;
         if (!last_st) begin
            r = int'($urandom_range(9));
            set_d(1'($urandom_range(7) != 0),
                  5'($urandom_range(3)), 2'($urandom_range(3)),
                  5'($urandom_range(3)), 2'($urandom_range(3)),
                  1'($urandom_range(1)), 5'($urandom_range(3)), 2'($urandom_range(2)),
                  1'(r == 0), 1'($urandom_range(1)), 1'(r < 3));
         end
         reset = ($urandom_range(99) == 0);
         step();
      end
      reset = 0;
      running = 0;
      chk("scoreboard_drained", 4'(exp_q.size()), 4'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
